// File: rtl/param_updown_counter.sv
// param_updown_counter
//  General-purpose up/down counter primitive for the game datapath:
//  programmable modulus, parallel load, synchronous and asynchronous
//  clear, dual count enables (CTP local, CTT cascade) and a ripple carry
//  out so that several instances chain into wider or mixed-radix counters.
//  Q, TC_PULSE and OVF are registered; RCO is combinational so that a
//  cascade settles within one clock period.
module param_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter bit WRAP    = 1'b1
) (
  input  logic             CP,
  input  logic             CRbar,
  input  logic             SCLRbar,
  input  logic             LDbar,
  input  logic             CTP,
  input  logic             CTT,
  input  logic             UD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             RCO,
  output logic             TC_PULSE,
  output logic             OVF
);

  // Largest legal count, all-zero value and unit step, sized to the counter.
  localparam logic [WIDTH-1:0] MAX_Q  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(32'd1);
  // Modulus carried one bit wider so MODULUS == 2**WIDTH stays representable.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;

  logic [WIDTH-1:0] term_s;
  logic             oob_s;
  logic             at_term_s;
  logic             en_s;
  logic [WIDTH-1:0] load_val_s;
  logic [WIDTH-1:0] q_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_nxt_s;

  // Terminal value for the current direction, range checks and clamped load data.
  always_comb begin
    term_s    = UD ? MAX_Q : ZERO_Q;
    // An out-of-range Q can only come from X-propagation; treat it as terminal
    // so an enabled edge pulls it back into range instead of stepping past it.
    oob_s     = ({1'b0, q_r} >= MOD_EXT);
    at_term_s = (q_r == term_s) || oob_s;
    en_s      = CTP & CTT;
    if ({1'b0, D} >= MOD_EXT) begin
      load_val_s = MAX_Q;
    end else begin
      load_val_s = D;
    end
  end

  // Prioritised next-state: sync clear, load, count, terminal handling, hold.
  always_comb begin
    q_nxt_s   = q_r;
    tc_nxt_s  = 1'b0;
    ovf_nxt_s = ovf_r;
    if (!SCLRbar) begin
      q_nxt_s   = ZERO_Q;
      ovf_nxt_s = 1'b0;
    end else if (!LDbar) begin
      q_nxt_s = load_val_s;
    end else if (en_s) begin
      if (at_term_s) begin
        tc_nxt_s  = 1'b1;
        ovf_nxt_s = 1'b1;
        if (WRAP) begin
          q_nxt_s = UD ? ZERO_Q : MAX_Q;
        end else begin
          q_nxt_s = q_r;
        end
      end else if (UD) begin
        // Not terminal, so q_r < MAX_Q and the step cannot leave the range.
        q_nxt_s = q_r + ONE_Q;
      end else begin
        q_nxt_s = q_r - ONE_Q;
      end
    end else begin
      q_nxt_s = q_r;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CP or negedge CRbar) begin
    if (!CRbar) begin
      q_r   <= ZERO_Q;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      tc_r  <= tc_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  // Ripple carry ignores CTP and tracks UD combinationally for cascading.
  assign RCO      = CTT & (q_r == term_s);
  assign Q        = q_r;
  assign TC_PULSE = tc_r;
  assign OVF      = ovf_r;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter
//  Drives a wrapping and a saturating modulo-10 counter from shared inputs,
//  plus a two-digit cascade, and compares every output against an
//  arithmetic reference model kept here.
module tb_param_updown_counter;

  localparam int M = 10;

  logic       cp = 1'b0;
  logic       crbar = 1'b0;
  logic       sclr = 1'b1;
  logic       ld = 1'b1;
  logic       ctp = 1'b0;
  logic       ctt = 1'b0;
  logic       ud = 1'b1;
  logic [3:0] d = 4'd0;
  logic       ctp_c = 1'b0;
  logic       ctt_c = 1'b0;
  logic       ud_c = 1'b1;
  logic       ld_c = 1'b1;
  logic [3:0] d_c = 4'd0;

  logic [3:0] q_w, q_s, q_lo, q_hi;
  logic       rco_w, tc_w, ovf_w;
  logic       rco_s, tc_s, ovf_s;
  logic       rco_lo, tc_lo, ovf_lo;
  logic       rco_hi, tc_hi, ovf_hi;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_w = 0, t_w = 0, o_w = 0;
  int m_s = 0, t_s = 0, o_s = 0;
  int cc = 0;

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_wrap (
    .CP(cp), .CRbar(crbar), .SCLRbar(sclr), .LDbar(ld), .CTP(ctp), .CTT(ctt),
    .UD(ud), .D(d), .Q(q_w), .RCO(rco_w), .TC_PULSE(tc_w), .OVF(ovf_w));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b0)) u_sat (
    .CP(cp), .CRbar(crbar), .SCLRbar(sclr), .LDbar(ld), .CTP(ctp), .CTT(ctt),
    .UD(ud), .D(d), .Q(q_s), .RCO(rco_s), .TC_PULSE(tc_s), .OVF(ovf_s));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_lo (
    .CP(cp), .CRbar(crbar), .SCLRbar(sclr), .LDbar(ld_c), .CTP(ctp_c), .CTT(ctt_c),
    .UD(ud_c), .D(d_c), .Q(q_lo), .RCO(rco_lo), .TC_PULSE(tc_lo), .OVF(ovf_lo));

  param_updown_counter #(.WIDTH(4), .MODULUS(10), .WRAP(1'b1)) u_hi (
    .CP(cp), .CRbar(crbar), .SCLRbar(sclr), .LDbar(ld_c), .CTP(ctp_c), .CTT(rco_lo),
    .UD(ud_c), .D(d_c), .Q(q_hi), .RCO(rco_hi), .TC_PULSE(tc_hi), .OVF(ovf_hi));

  // free-running clock
  always #5 cp = ~cp;

  // global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One edge of a modulo-M counter described arithmetically.
  task automatic model_one(input int wrapm, input int m, input int o,
                           output int mn, output int tn, output int on);
    int stepped;
    mn = m; tn = 0; on = o;
    if (!sclr) begin
      mn = 0; on = 0;
    end else if (!ld) begin
      mn = (int'(d) >= M) ? M - 1 : int'(d);
    end else if (ctp && ctt) begin
      stepped = ud ? m + 1 : m - 1;
      if (stepped < 0 || stepped >= M) begin
        tn = 1; on = 1;
        mn = wrapm ? (stepped + M) % M : m;
      end else begin
        mn = stepped;
      end
    end
  endtask

  task automatic model_reset();
    m_w = 0; t_w = 0; o_w = 0;
    m_s = 0; t_s = 0; o_s = 0;
    cc = 0;
  endtask

  // Advance one clock edge, update model, check registered outputs.
  task automatic step();
    @(posedge cp);
    model_one(1, m_w, o_w, m_w, t_w, o_w);
    model_one(0, m_s, o_s, m_s, t_s, o_s);
    if (!sclr) cc = 0;
    else if (ctp_c && ctt_c) cc = (cc + (ud_c ? 1 : 99)) % 100;
    #1;
    chk("q_wrap", q_w, m_w);
    chk("tc_wrap", tc_w, t_w);
    chk("ovf_wrap", ovf_w, o_w);
    chk("q_sat", q_s, m_s);
    chk("tc_sat", tc_s, t_s);
    chk("ovf_sat", ovf_s, o_s);
    chk("q_lo", q_lo, cc % 10);
    chk("q_hi", q_hi, cc / 10);
  endtask

  // Check combinational carries after inputs have been changed.
  task automatic check_comb();
    int lo_t, hi_t;
    #1;
    chk("rco_wrap", rco_w, (ctt && m_w == (ud ? M - 1 : 0)) ? 1 : 0);
    chk("rco_sat", rco_s, (ctt && m_s == (ud ? M - 1 : 0)) ? 1 : 0);
    lo_t = (ctt_c && (cc % 10) == (ud_c ? 9 : 0)) ? 1 : 0;
    hi_t = (lo_t == 1 && (cc / 10) == (ud_c ? 9 : 0)) ? 1 : 0;
    chk("rco_lo", rco_lo, lo_t);
    chk("rco_hi", rco_hi, hi_t);
  endtask

  initial begin
    int exp_q[4];
    int exp_tc[4];
    exp_q  = '{1, 0, 0, 0};
    exp_tc = '{0, 0, 1, 1};

    // reset state while CRbar held low across edges
    #22;
    chk("rst_q", q_w, 0);
    chk("rst_tc", tc_w, 0);
    chk("rst_ovf", ovf_w, 0);
    crbar = 1'b1;

    // T1: count to 5, asynchronous clear mid-cycle, then first edge gives 1
    ctp = 1'b1; ctt = 1'b1; ud = 1'b1;
    check_comb();
    repeat (5) step();
    chk("t1_q5", q_w, 5);
    #2; crbar = 1'b0; #1;
    model_reset();
    chk("t1_async_q", q_w, 0);
    chk("t1_async_tc", tc_w, 0);
    chk("t1_async_ovf", ovf_w, 0);
    chk("t1_async_qs", q_s, 0);
    #2; crbar = 1'b1;
    step();
    chk("t1_first", q_w, 1);

    // T2: modulo-10 wrap from 0
    sclr = 1'b0; check_comb(); step(); sclr = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check_comb();
      step();
      chk("t2_q", q_w, (i + 1) % 10);
    end
    chk("t2_tc", tc_w, 1);
    chk("t2_ovf", ovf_w, 1);
    ctp = 1'b0; check_comb(); step();
    chk("t2_tc_drop", tc_w, 0);

    // T3: load 2, count down into saturation
    ud = 1'b0; ld = 1'b0; d = 4'd2; check_comb(); step();
    ld = 1'b1; ctp = 1'b1; ctt = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_comb();
      step();
      chk("t3_q", q_s, exp_q[i]);
      chk("t3_tc", tc_s, exp_tc[i]);
    end
    chk("t3_rco", rco_s, 1);

    // T4: sync clear beats load and count; load clamps to MODULUS-1
    ud = 1'b1; sclr = 1'b0; ld = 1'b0; d = 4'd7; check_comb(); step();
    chk("t4_sclr_q", q_w, 0);
    chk("t4_sclr_ovf", ovf_w, 0);
    sclr = 1'b1; d = 4'd12; check_comb(); step();
    chk("t4_clamp", q_w, 9);
    chk("t4_clamp_s", q_s, 9);
    ld = 1'b1;

    // T5: enables
    ctp = 1'b0; ctt = 1'b1; check_comb();
    chk("t5_rco_ctp0", rco_w, 1);
    step();
    chk("t5_hold1", q_w, 9);
    ctp = 1'b1; ctt = 1'b0; check_comb();
    chk("t5_rco_ctt0", rco_w, 0);
    step();
    chk("t5_hold2", q_w, 9);

    // T6: two-digit cascade
    ctp = 1'b0; sclr = 1'b0; check_comb(); step(); sclr = 1'b1;
    ctp_c = 1'b1; ctt_c = 1'b1; ud_c = 1'b1;
    repeat (99) begin check_comb(); step(); end
    chk("t6_hi99", q_hi, 9);
    chk("t6_lo99", q_lo, 9);
    check_comb(); step();
    chk("t6_hi0", q_hi, 0);
    chk("t6_lo0", q_lo, 0);

    // randomized phase
    repeat (600) begin
      sclr  = ($urandom_range(0, 31) != 0);
      ld    = ($urandom_range(0, 9) != 0);
      ctp   = ($urandom_range(0, 3) != 0);
      ctt   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) ud = ~ud;
      d     = 4'($urandom_range(0, 15));
      ctp_c = ($urandom_range(0, 3) != 0);
      ctt_c = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) ud_c = ~ud_c;
      check_comb();
      step();
      if ($urandom_range(0, 63) == 0) begin
        #2; crbar = 1'b0; #1;
        model_reset();
        chk("rnd_async_q", q_w, 0);
        chk("rnd_async_ovf", ovf_s, 0);
        #2; crbar = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
